mem_port_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port synchronous Memory in the A09 system.
- Requesters are the CPU core (C_*: fetch and load/store) and a program loader/debug port (L_*: host download and inspection).
- Registers each winning request, drives the memory port for one cycle, then returns an Ack with read data.
- Fairness is round-robin. A loader lock gives the loader exclusive access while the CPU is held off.

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: the CPU and loader request/ack channels
// plus the single-port memory connection. The arbiter takes the slave view;
// the requesters and memory together take the master view.
interface mem_port_arbiter_if #(
    parameter int DataWidth = 8,
    parameter int AddrWidth = 8
) ();

    // CPU requester channel
    logic                 C_Req;
    logic                 C_Wr;
    logic [AddrWidth-1:0] C_Addr;
    logic [DataWidth-1:0] C_DIn;
    logic                 C_Ack;
    logic [DataWidth-1:0] C_DOut;

    // Loader / debug requester channel
    logic                 L_Req;
    logic                 L_Wr;
    logic [AddrWidth-1:0] L_Addr;
    logic [DataWidth-1:0] L_DIn;
    logic                 L_Lock;
    logic                 L_Ack;
    logic [DataWidth-1:0] L_DOut;

    // Memory port (registered read, one cycle of latency)
    logic [AddrWidth-1:0] M_Addr;
    logic [DataWidth-1:0] M_DIn;
    logic                 M_WrEn;
    logic [DataWidth-1:0] M_DOut;

    // Arbiter side
    modport slave (
        input  C_Req, C_Wr, C_Addr, C_DIn,
        output C_Ack, C_DOut,
        input  L_Req, L_Wr, L_Addr, L_DIn, L_Lock,
        output L_Ack, L_DOut,
        output M_Addr, M_DIn, M_WrEn,
        input  M_DOut
    );

    // Requester and memory side
    modport master (
        output C_Req, C_Wr, C_Addr, C_DIn,
        input  C_Ack, C_DOut,
        output L_Req, L_Wr, L_Addr, L_DIn, L_Lock,
        input  L_Ack, L_DOut,
        input  M_Addr, M_DIn, M_WrEn,
        output M_DOut
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the A09 single-port synchronous memory.
// A transaction is IDLE/RESP -> ACCESS (memory port driven one cycle) -> RESP
// (Ack pulse with read data). Round-robin between CPU and loader; L_Lock
// locks the CPU out at every arbitration point while it is high.
module mem_port_arbiter #(
    parameter int DataWidth = 8,
    parameter int AddrWidth = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    mem_port_arbiter_if.slave   bus,
    output logic                Owner,
    output logic                Busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Requester encoding used for owner_q / last_grant_q
    localparam logic REQ_CPU    = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    state_e               state_q;
    logic                 last_grant_q;
    logic                 owner_q;
    logic                 busy_q;
    logic                 wren_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] din_q;
    logic                 c_ack_q;
    logic                 l_ack_q;

    // Arbitration result for the current edge
    logic                 c_elig_d;
    logic                 l_elig_d;
    logic                 grant_valid_d;
    logic                 grant_loader_d;
    logic                 sel_wr_d;
    logic [AddrWidth-1:0] sel_addr_d;
    logic [DataWidth-1:0] sel_din_d;

    // Decide the winner from Req/Lock and pick its command fields
    always_comb begin
        // NOTE: every combinational output gets a value on every path first, so no latch is inferred.
        c_elig_d       = 1'b0;
        l_elig_d       = 1'b0;
        grant_valid_d  = 1'b0;
        grant_loader_d = REQ_CPU;
        sel_wr_d       = bus.C_Wr;
        sel_addr_d     = bus.C_Addr;
        sel_din_d      = bus.C_DIn;

        // The lock stalls the CPU even when the loader is not requesting.
        c_elig_d = bus.C_Req & ~bus.L_Lock;
        l_elig_d = bus.L_Req;

        grant_valid_d = c_elig_d | l_elig_d;
        // Loader wins when it is the only one, or on a tie when the CPU had the last grant.
        grant_loader_d = l_elig_d & (~c_elig_d | (last_grant_q == REQ_CPU));

        if (grant_loader_d) begin
            sel_wr_d   = bus.L_Wr;
            sel_addr_d = bus.L_Addr;
            sel_din_d  = bus.L_DIn;
        end
    end

    // Transaction sequencer with registered memory-port and Ack outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            // Asynchronous clear also kills any write still waiting for its clock edge.
            state_q      <= ST_IDLE;
            last_grant_q <= REQ_LOADER;
            owner_q      <= REQ_CPU;
            busy_q       <= 1'b0;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            c_ack_q      <= 1'b0;
            l_ack_q      <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    c_ack_q <= 1'b0;
                    l_ack_q <= 1'b0;
                    wren_q  <= 1'b0;
                    if (grant_valid_d) begin
                        state_q      <= ST_ACCESS;
                        busy_q       <= 1'b1;
                        owner_q      <= grant_loader_d;
                        last_grant_q <= grant_loader_d;
                        addr_q       <= sel_addr_d;
                        din_q        <= sel_din_d;
                        wren_q       <= sel_wr_d;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                ST_ACCESS: begin
                    // Memory performs the access on this edge; requester inputs are ignored.
                    state_q <= ST_RESP;
                    busy_q  <= 1'b1;
                    wren_q  <= 1'b0;
                    c_ack_q <= (owner_q == REQ_CPU);
                    l_ack_q <= (owner_q == REQ_LOADER);
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    wren_q  <= 1'b0;
                    c_ack_q <= 1'b0;
                    l_ack_q <= 1'b0;
                end
            endcase
        end
    end

    // Memory port follows the latched command; M_WrEn is high only in ACCESS.
    assign bus.M_Addr = addr_q;
    assign bus.M_DIn  = din_q;
    assign bus.M_WrEn = wren_q;

    // Registered memory read data is routed only to the acked requester.
    assign bus.C_Ack  = c_ack_q;
    assign bus.L_Ack  = l_ack_q;
    assign bus.C_DOut = c_ack_q ? bus.M_DOut : '0;
    assign bus.L_DOut = l_ack_q ? bus.M_DOut : '0;

    assign Owner = owner_q;
    assign Busy  = busy_q;

`ifndef SYNTHESIS
    // Structural invariants of the sequencer
    a_ack_onehot: assert property (@(posedge Clk) disable iff (!Reset)
        !(c_ack_q && l_ack_q));
    a_wren_in_access: assert property (@(posedge Clk) disable iff (!Reset)
        wren_q |-> (state_q == ST_ACCESS));
    a_ack_in_resp: assert property (@(posedge Clk) disable iff (!Reset)
        (c_ack_q || l_ack_q) |-> (state_q == ST_RESP));
    a_busy_state: assert property (@(posedge Clk) disable iff (!Reset)
        busy_q == (state_q != ST_IDLE));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected Ack events
// (who, cycle, read data) into a scoreboard; a negedge monitor pops them when
// the DUT acks. A behavioural registered-read memory closes the loop.
module tb_mem_port_arbiter;

    logic Clk;
    logic Reset;
    logic Owner;
    logic Busy;
    int   cyc;

    int n_cmp;
    int n_err;

    mem_port_arbiter_if #(.DataWidth(8), .AddrWidth(8)) bus ();

    mem_port_arbiter #(.DataWidth(8), .AddrWidth(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus),
        .Owner (Owner),
        .Busy  (Busy)
    );

    typedef struct {
        bit         loader;
        bit         chk_data;
        logic [7:0] data;
        int         cycle;
    } exp_t;

    exp_t sb[$];

    logic [7:0] mem [256];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Synchronous memory: write on WrEn, registered read of the same address.
    always @(posedge Clk) begin
        if (bus.M_WrEn) mem[bus.M_Addr] <= bus.M_DIn;
        bus.M_DOut <= mem[bus.M_Addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input bit loader, input bit chk, input logic [7:0] data, input int cycle);
        exp_t e;
        e.loader   = loader;
        e.chk_data = chk;
        e.data     = data;
        e.cycle    = cycle;
        sb.push_back(e);
    endtask

    // Monitor: compare each Ack against the head of the scoreboard.
    always @(negedge Clk) begin
        exp_t e;
        if (bus.C_Ack === 1'b1 || bus.L_Ack === 1'b1) begin
            if (sb.size() == 0) begin
                check("ack_unexpected", {30'd0, bus.C_Ack, bus.L_Ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_who", {30'd0, bus.C_Ack, bus.L_Ack}, e.loader ? 32'd1 : 32'd2);
                check("ack_cycle", cyc, e.cycle);
                if (e.chk_data)
                    check("rd_data", e.loader ? {24'd0, bus.L_DOut} : {24'd0, bus.C_DOut}, {24'd0, e.data});
                check("other_dout", e.loader ? {24'd0, bus.C_DOut} : {24'd0, bus.L_DOut}, 32'd0);
            end
        end else begin
            check("idle_dout", {16'd0, bus.C_DOut, bus.L_DOut}, 32'd0);
        end
    end

    // One uncontended access; request dropped right after the grant edge.
    task automatic single(input bit ld, input bit wr, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] rd_exp);
        tick();
        if (ld) begin
            bus.L_Req = 1'b1; bus.L_Wr = wr; bus.L_Addr = a; bus.L_DIn = d;
        end else begin
            bus.C_Req = 1'b1; bus.C_Wr = wr; bus.C_Addr = a; bus.C_DIn = d;
        end
        push(ld, !wr, rd_exp, cyc + 2);
        tick();
        check("single_owner", {31'd0, Owner}, {31'd0, ld});
        check("single_wren", {31'd0, bus.M_WrEn}, {31'd0, wr});
        check("single_addr", {24'd0, bus.M_Addr}, {24'd0, a});
        bus.C_Req = 1'b0;
        bus.L_Req = 1'b0;
        tick();
        check("single_resp_wren", {31'd0, bus.M_WrEn}, 32'd0);
        tick();
        check("single_idle_busy", {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        int e0;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h20] = 8'h00;

        Reset = 1'b0;
        bus.C_Req = 1'b0; bus.C_Wr = 1'b0; bus.C_Addr = '0; bus.C_DIn = '0;
        bus.L_Req = 1'b0; bus.L_Wr = 1'b0; bus.L_Addr = '0; bus.L_DIn = '0;
        bus.L_Lock = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_c_ack", {31'd0, bus.C_Ack}, 32'd0);
        check("rst_l_ack", {31'd0, bus.L_Ack}, 32'd0);
        check("rst_wren", {31'd0, bus.M_WrEn}, 32'd0);
        check("rst_addr", {24'd0, bus.M_Addr}, 32'd0);
        check("rst_din", {24'd0, bus.M_DIn}, 32'd0);
        check("rst_owner", {31'd0, Owner}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        Reset = 1'b1;

        // CPU write 10 <- A5 held until its Ack, then read back
        tick();
        e0 = cyc;
        bus.C_Req = 1'b1; bus.C_Wr = 1'b1; bus.C_Addr = 8'h10; bus.C_DIn = 8'hA5;
        push(1'b0, 1'b0, 8'h00, e0 + 2);
        tick();
        check("t1_wren_access", {31'd0, bus.M_WrEn}, 32'd1);
        check("t1_owner", {31'd0, Owner}, 32'd0);
        check("t1_busy", {31'd0, Busy}, 32'd1);
        check("t1_maddr", {24'd0, bus.M_Addr}, 32'h10);
        check("t1_mdin", {24'd0, bus.M_DIn}, 32'hA5);
        check("t1_no_ack_yet", {31'd0, bus.C_Ack}, 32'd0);
        tick();
        check("t1_ack", {31'd0, bus.C_Ack}, 32'd1);
        check("t1_wren_resp", {31'd0, bus.M_WrEn}, 32'd0);
        bus.C_Req = 1'b0;
        tick();
        check("t1_idle", {31'd0, Busy}, 32'd0);
        single(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);

        // Both requesters held from reset: C, L, C, L every 2 cycles
        tick();
        Reset = 1'b0;
        bus.C_Req = 1'b1; bus.C_Wr = 1'b0; bus.C_Addr = 8'h01;
        bus.L_Req = 1'b1; bus.L_Wr = 1'b0; bus.L_Addr = 8'h02;
        tick();
        tick();
        check("t2_busy_in_reset", {31'd0, Busy}, 32'd0);
        e0 = cyc;
        Reset = 1'b1;
        push(1'b0, 1'b1, 8'h5B, e0 + 2);
        push(1'b1, 1'b1, 8'h58, e0 + 4);
        push(1'b0, 1'b1, 8'h5B, e0 + 6);
        push(1'b1, 1'b1, 8'h58, e0 + 8);
        repeat (8) tick();
        bus.C_Req = 1'b0;
        bus.L_Req = 1'b0;
        tick();
        tick();
        check("t2_idle", {31'd0, Busy}, 32'd0);

        // Lock with no loader request stalls the CPU
        tick();
        e0 = cyc;
        bus.L_Lock = 1'b1;
        bus.C_Req = 1'b1; bus.C_Wr = 1'b0; bus.C_Addr = 8'h33;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_locked_busy", {31'd0, Busy}, 32'd0);
            check("t3_locked_ack", {31'd0, bus.C_Ack}, 32'd0);
        end
        bus.L_Lock = 1'b0;
        push(1'b0, 1'b1, 8'h69, e0 + 12);
        tick();
        check("t3_grant_busy", {31'd0, Busy}, 32'd1);
        check("t3_grant_owner", {31'd0, Owner}, 32'd0);
        bus.C_Req = 1'b0;
        tick();
        tick();

        // Loader write under lock while the CPU waits, then CPU reads it back
        tick();
        e0 = cyc;
        bus.L_Lock = 1'b1;
        bus.L_Req = 1'b1; bus.L_Wr = 1'b1; bus.L_Addr = 8'hFF; bus.L_DIn = 8'h3C;
        bus.C_Req = 1'b1; bus.C_Wr = 1'b0; bus.C_Addr = 8'hFF;
        push(1'b1, 1'b0, 8'h00, e0 + 2);
        tick();
        check("t4_owner_loader", {31'd0, Owner}, 32'd1);
        check("t4_wren", {31'd0, bus.M_WrEn}, 32'd1);
        bus.L_Req = 1'b0;
        bus.L_Wr = 1'b0;
        tick();
        tick();
        check("t4_cpu_still_stalled", {31'd0, Busy}, 32'd0);
        bus.L_Lock = 1'b0;
        push(1'b0, 1'b1, 8'h3C, e0 + 5);
        tick();
        check("t4_cpu_owner", {31'd0, Owner}, 32'd0);
        bus.C_Req = 1'b0;
        tick();
        tick();

        // Reset during ACCESS of a CPU write drops the write
        tick();
        bus.C_Req = 1'b1; bus.C_Wr = 1'b1; bus.C_Addr = 8'h20; bus.C_DIn = 8'h77;
        tick();
        check("t5_wren_before", {31'd0, bus.M_WrEn}, 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        check("t5_wren_dropped", {31'd0, bus.M_WrEn}, 32'd0);
        check("t5_acks", {30'd0, bus.C_Ack, bus.L_Ack}, 32'd0);
        check("t5_busy", {31'd0, Busy}, 32'd0);
        check("t5_addr", {24'd0, bus.M_Addr}, 32'd0);
        bus.C_Req = 1'b0;
        bus.C_Wr = 1'b0;
        tick();
        Reset = 1'b1;
        single(1'b0, 1'b0, 8'h20, 8'h00, 8'h00);

        // Loader keeps Req high through its Ack with a new address
        tick();
        e0 = cyc;
        bus.L_Req = 1'b1; bus.L_Wr = 1'b0; bus.L_Addr = 8'h40;
        push(1'b1, 1'b1, 8'h1A, e0 + 2);
        push(1'b1, 1'b1, 8'h1B, e0 + 4);
        tick();
        tick();
        check("t6_first_ack", {31'd0, bus.L_Ack}, 32'd1);
        bus.L_Addr = 8'h41;
        tick();
        check("t6_second_busy", {31'd0, Busy}, 32'd1);
        check("t6_second_addr", {24'd0, bus.M_Addr}, 32'h41);
        tick();
        check("t6_second_ack", {31'd0, bus.L_Ack}, 32'd1);
        bus.L_Req = 1'b0;
        tick();
        check("t6_idle", {31'd0, Busy}, 32'd0);

        repeat (3) tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
